tf_step_sequencer: RTL and testbench

Stimulus controller for a fixed-point analog-model filter block (v_in -> v_out). It drives v_in through a programmed table of step levels and holds each step until v_out settles or times out. After each step it reports the settled v_out with a valid/ready handshake. It sits in the bench or emulation top beside the filter and replaces a constant v_in source with sequenced step-response measurement.

---
 rtl/tf_step_sequencer_if.sv | 32 +++
 rtl/tf_step_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_tf_step_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tf_step_sequencer_if.sv
// Result handshake bundle between the step sequencer and its consumer.
//   res_valid   : sequencer -> consumer, a captured step result is on offer
//   res_ready   : consumer -> sequencer, result accepted on valid & ready
//   res_value   : captured signed v_out for the step
//   res_idx     : table index of the step that produced the result
//   res_timeout : result was captured on timeout rather than on settle
interface tf_step_sequencer_if #(
    parameter int WIDTH = 18,
    parameter int IDX_W = 2
);
    logic                    res_valid;
    logic                    res_ready;
    logic signed [WIDTH-1:0] res_value;
    logic [IDX_W-1:0]        res_idx;
    logic                    res_timeout;

    modport master (
        output res_valid,
        output res_value,
        output res_idx,
        output res_timeout,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_value,
        input  res_idx,
        input  res_timeout,
        output res_ready
    );
endinterface

// File: rtl/tf_step_sequencer.sv
// Step-response stimulus controller for a fixed-point filter model.
// Drives v_in through a programmed table of levels, holds each level until
// v_out settles (or the step times out), then offers the captured v_out on
// a valid/ready result channel before moving to the next table entry.
//
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   cfg_we/addr/level : level table write port, honoured only in IDLE
//   n_steps         : number of entries to run, sampled on start
//   min_hold        : cycles per step before settle checking begins
//   max_hold        : per-step timeout, counted from step entry
//   start, abort    : sequence control (abort wins over everything)
//   v_out           : filter output being observed
//   v_in            : registered filter input
//   res             : result handshake (master side)
//   busy            : high whenever not IDLE
//   done            : one-cycle pulse after the last result is accepted
module tf_step_sequencer #(
    parameter int WIDTH      = 18,
    parameter int N_STEPS    = 4,
    parameter int CNT_W      = 16,
    parameter int TOL        = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [$clog2(N_STEPS)-1:0]  cfg_addr,
    input  logic signed [WIDTH-1:0]     cfg_level,
    input  logic [$clog2(N_STEPS):0]    n_steps,
    input  logic [CNT_W-1:0]            min_hold,
    input  logic [CNT_W-1:0]            max_hold,
    input  logic                        start,
    input  logic                        abort,
    input  logic signed [WIDTH-1:0]     v_out,
    output logic signed [WIDTH-1:0]     v_in,
    tf_step_sequencer_if.master         res,
    output logic                        busy,
    output logic                        done
);

    localparam int IDX_W = $clog2(N_STEPS);
    localparam int NS_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    // Magnitude of a WIDTH+1 bit signed difference; cannot overflow because
    // the difference of two WIDTH-bit values never reaches -2^WIDTH.
    function automatic logic [WIDTH:0] abs_delta(input logic signed [WIDTH:0] d);
        if (d[WIDTH]) begin
            abs_delta = $unsigned(-d);
        end else begin
            abs_delta = $unsigned(d);
        end
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic signed [WIDTH-1:0] table_r [N_STEPS];
    logic [IDX_W-1:0]        idx_r;
    logic [NS_W-1:0]         n_lat_r;
    logic [CNT_W-1:0]        hold_cnt_r;
    logic [CNT_W-1:0]        stable_cnt_r;
    logic signed [WIDTH-1:0] v_out_q_r;
    logic signed [WIDTH-1:0] v_in_r;
    logic                    res_valid_r;
    logic signed [WIDTH-1:0] res_value_r;
    logic [IDX_W-1:0]        res_idx_r;
    logic                    res_timeout_r;
    logic                    busy_r;
    logic                    done_r;

    logic signed [WIDTH:0]   delta_s;
    logic                    settled_s;
    logic                    n_ok_s;
    logic                    settle_hit_s;
    logic                    timeout_hit_s;
    logic                    more_s;
    logic                    start_ok_s;
    logic                    capture_s;
    logic                    timeout_s;
    logic                    advance_s;
    logic                    finish_s;

    assign v_in            = v_in_r;
    assign res.res_valid   = res_valid_r;
    assign res.res_value   = res_value_r;
    assign res.res_idx     = res_idx_r;
    assign res.res_timeout = res_timeout_r;
    assign busy            = busy_r;
    assign done            = done_r;

    // Settle detection: per-cycle delta, forced to zero on the step entry cycle.
    always_comb begin
        delta_s   = {(WIDTH+1){1'b0}};
        settled_s = 1'b0;
        if (hold_cnt_r == {CNT_W{1'b0}}) begin
            delta_s = {(WIDTH+1){1'b0}};
        end else begin
            delta_s = $signed({v_out[WIDTH-1], v_out}) - $signed({v_out_q_r[WIDTH-1], v_out_q_r});
        end
        settled_s = (abs_delta(delta_s) <= (WIDTH+1)'(TOL));
    end

    // Sequence qualifiers used by the next-state logic.
    always_comb begin
        n_ok_s        = (n_steps != {NS_W{1'b0}}) && (n_steps <= NS_W'(N_STEPS));
        settle_hit_s  = (stable_cnt_r >= CNT_W'(SETTLE_CYC));
        // hold_cnt + 1 >= max_hold, widened so max_hold of 0 or 1 times out at once
        timeout_hit_s = (({1'b0, hold_cnt_r} + (CNT_W+1)'(1)) >= {1'b0, max_hold});
        more_s        = (({1'b0, idx_r} + NS_W'(1)) < n_lat_r);
    end

    // FSM next-state and per-cycle event decode.
    always_comb begin
        state_nxt_s = state_r;
        start_ok_s  = 1'b0;
        capture_s   = 1'b0;
        timeout_s   = 1'b0;
        advance_s   = 1'b0;
        finish_s    = 1'b0;
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && n_ok_s) begin
                        state_nxt_s = ST_HOLD;
                        start_ok_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    // settle takes precedence over a coincident timeout
                    if (settle_hit_s) begin
                        state_nxt_s = ST_REPORT;
                        capture_s   = 1'b1;
                    end else if (timeout_hit_s) begin
                        state_nxt_s = ST_REPORT;
                        capture_s   = 1'b1;
                        timeout_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_REPORT: begin
                    if (res_valid_r && res.res_ready) begin
                        if (more_s) begin
                            state_nxt_s = ST_HOLD;
                            advance_s   = 1'b1;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            finish_s    = 1'b1;
                        end
                    end else begin
                        state_nxt_s = ST_REPORT;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Level table: programmable only while IDLE, deliberately not reset.
    always_ff @(posedge clk) begin
        if (cfg_we && (state_r == ST_IDLE)) begin
            table_r[cfg_addr] <= cfg_level;
        end else begin
            table_r[cfg_addr] <= table_r[cfg_addr];
        end
    end

    // State, counters, stimulus and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            idx_r         <= {IDX_W{1'b0}};
            n_lat_r       <= {NS_W{1'b0}};
            hold_cnt_r    <= {CNT_W{1'b0}};
            stable_cnt_r  <= {CNT_W{1'b0}};
            v_out_q_r     <= {WIDTH{1'b0}};
            v_in_r        <= {WIDTH{1'b0}};
            res_valid_r   <= 1'b0;
            res_value_r   <= {WIDTH{1'b0}};
            res_idx_r     <= {IDX_W{1'b0}};
            res_timeout_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= finish_s;
            v_out_q_r <= v_out;
            if (abort) begin
                idx_r        <= {IDX_W{1'b0}};
                hold_cnt_r   <= {CNT_W{1'b0}};
                stable_cnt_r <= {CNT_W{1'b0}};
                v_in_r       <= {WIDTH{1'b0}};
                res_valid_r  <= 1'b0;
            end else if (start_ok_s) begin
                n_lat_r      <= n_steps;
                idx_r        <= {IDX_W{1'b0}};
                hold_cnt_r   <= {CNT_W{1'b0}};
                stable_cnt_r <= {CNT_W{1'b0}};
                v_in_r       <= table_r[0];
            end else if (capture_s) begin
                res_valid_r   <= 1'b1;
                res_value_r   <= v_out;
                res_idx_r     <= idx_r;
                res_timeout_r <= timeout_s;
            end else if (advance_s) begin
                idx_r        <= idx_r + IDX_W'(1);
                hold_cnt_r   <= {CNT_W{1'b0}};
                stable_cnt_r <= {CNT_W{1'b0}};
                v_in_r       <= table_r[idx_r + IDX_W'(1)];
                res_valid_r  <= 1'b0;
            end else if (finish_s) begin
                idx_r        <= {IDX_W{1'b0}};
                hold_cnt_r   <= {CNT_W{1'b0}};
                stable_cnt_r <= {CNT_W{1'b0}};
                v_in_r       <= {WIDTH{1'b0}};
                res_valid_r  <= 1'b0;
            end else if (state_r == ST_HOLD) begin
                hold_cnt_r <= hold_cnt_r + CNT_W'(1);
                // stable run only counts once the minimum hold has elapsed
                if (hold_cnt_r >= min_hold) begin
                    if (settled_s) begin
                        stable_cnt_r <= stable_cnt_r + CNT_W'(1);
                    end else begin
                        stable_cnt_r <= {CNT_W{1'b0}};
                    end
                end else begin
                    stable_cnt_r <= {CNT_W{1'b0}};
                end
            end else begin
                hold_cnt_r   <= hold_cnt_r;
                stable_cnt_r <= stable_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_tf_step_sequencer.sv
// Directed testbench for tf_step_sequencer: reset/idle, settle, timeout,
// backpressure over four steps, abort, mid-sequence reset and boundary cases.
module tb_tf_step_sequencer;

    localparam int WIDTH = 18;
    localparam int NS    = 4;
    localparam int CNT_W = 16;

    logic                    clk;
    logic                    rst;
    logic                    cfg_we;
    logic [1:0]              cfg_addr;
    logic signed [WIDTH-1:0] cfg_level;
    logic [2:0]              n_steps;
    logic [CNT_W-1:0]        min_hold;
    logic [CNT_W-1:0]        max_hold;
    logic                    start;
    logic                    abort;
    logic signed [WIDTH-1:0] v_out;
    logic signed [WIDTH-1:0] v_in;
    logic                    busy;
    logic                    done;

    int checks;
    int errors;

    tf_step_sequencer_if #(.WIDTH(WIDTH), .IDX_W(2)) res_if ();

    tf_step_sequencer #(
        .WIDTH(WIDTH), .N_STEPS(NS), .CNT_W(CNT_W), .TOL(4), .SETTLE_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_level(cfg_level), .n_steps(n_steps), .min_hold(min_hold),
        .max_hold(max_hold), .start(start), .abort(abort), .v_out(v_out),
        .v_in(v_in), .res(res_if), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance one clock; returns at the following negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_level(input int addr, input int level);
        cfg_we    = 1'b1;
        cfg_addr  = 2'(addr);
        cfg_level = WIDTH'(level);
        tick();
        cfg_we    = 1'b0;
    endtask

    // start a run; returns during cycle 0 of step 0
    task automatic do_start(input int n);
        start   = 1'b1;
        n_steps = 3'(n);
        tick();
        start   = 1'b0;
    endtask

    // count cycles from the current cycle until res_valid, bounded
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!res_if.res_valid && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    int cyc;
    int lv [4];

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_level = '0;
        n_steps   = 3'd0;
        min_hold  = 16'd4;
        max_hold  = 16'd100;
        start     = 1'b0;
        abort     = 1'b0;
        v_out     = '0;
        res_if.res_ready = 1'b1;

        // reset and idle
        tick(); tick(); tick();
        check_eq("rst_v_in", v_in, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", res_if.res_valid, 0);
        check_eq("rst_done", done, 0);
        rst = 1'b1;
        tick();
        check_eq("idle_busy", busy, 0);
        do_start(0);
        check_eq("start_n0_busy", busy, 0);
        do_start(5);
        check_eq("start_n5_busy", busy, 0);
        check_eq("start_n5_v_in", v_in, 0);

        lv[0] = 1000; lv[1] = -100; lv[2] = 2000; lv[3] = -2000;
        for (int i = 0; i < 4; i++) write_level(i, lv[i]);

        // single-step settle with constant v_out
        v_out = 18'sd500;
        do_start(1);
        check_eq("settle_v_in0", v_in, 1000);
        check_eq("settle_busy", busy, 1);
        wait_valid(cyc);
        check_eq("settle_latency", cyc, 13);
        check_eq("settle_value", res_if.res_value, 500);
        check_eq("settle_to", res_if.res_timeout, 0);
        check_eq("settle_idx", res_if.res_idx, 0);
        tick();
        check_eq("settle_done", done, 1);
        check_eq("settle_valid_drop", res_if.res_valid, 0);
        check_eq("settle_v_in_idle", v_in, 0);
        check_eq("settle_busy_idle", busy, 0);
        tick();
        check_eq("settle_done_pulse", done, 0);

        // timeout: v_out toggles by 20 LSB every cycle
        min_hold = 16'd2;
        max_hold = 16'd20;
        v_out    = -18'sd10;
        do_start(1);
        cyc = 0;
        while (!res_if.res_valid && cyc < 400) begin
            v_out = cyc[0] ? 18'sd10 : -18'sd10;
            tick();
            cyc++;
        end
        check_eq("to_latency", cyc, 20);
        check_eq("to_flag", res_if.res_timeout, 1);
        check_eq("to_value", res_if.res_value, 10);
        tick();
        check_eq("to_done", done, 1);

        // backpressure over four steps, with a cfg write attempted mid-run
        write_level(0, 100);
        lv[0] = 100;
        min_hold = 16'd4;
        max_hold = 16'd100;
        res_if.res_ready = 1'b0;
        do_start(4);
        for (int k = 0; k < 4; k++) begin
            check_eq("bp_v_in_entry", v_in, lv[k]);
            v_out = WIDTH'(k * 7 + 3);
            if (k == 0) begin
                cfg_we = 1'b1; cfg_addr = 2'd1; cfg_level = 18'sd555;
            end
            tick();
            cfg_we = 1'b0;
            wait_valid(cyc);
            check_eq("bp_latency", cyc, 12);
            for (int w = 0; w < 5; w++) begin
                check_eq("bp_valid_hold", res_if.res_valid, 1);
                check_eq("bp_idx", res_if.res_idx, k);
                check_eq("bp_value", res_if.res_value, k * 7 + 3);
                check_eq("bp_v_in_hold", v_in, lv[k]);
                tick();
            end
            res_if.res_ready = 1'b1;
            tick();
            res_if.res_ready = 1'b0;
            check_eq("bp_valid_drop", res_if.res_valid, 0);
            if (k < 3) begin
                check_eq("bp_busy", busy, 1);
                check_eq("bp_no_done", done, 0);
            end else begin
                check_eq("bp_done", done, 1);
                check_eq("bp_v_in_idle", v_in, 0);
            end
        end
        tick();

        // abort during step 2 together with a start request
        res_if.res_ready = 1'b1;
        v_out = 18'sd0;
        do_start(4);
        wait_valid(cyc);
        tick();
        check_eq("ab_step1_v_in", v_in, -100);
        wait_valid(cyc);
        tick();
        check_eq("ab_step2_v_in", v_in, 2000);
        tick(); tick(); tick();
        abort = 1'b1;
        start = 1'b1;
        n_steps = 3'd4;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_eq("ab_busy", busy, 0);
        check_eq("ab_v_in", v_in, 0);
        check_eq("ab_valid", res_if.res_valid, 0);
        check_eq("ab_done", done, 0);
        tick();
        check_eq("ab_done_later", done, 0);
        check_eq("ab_busy_later", busy, 0);
        do_start(1);
        check_eq("ab_rerun_v_in", v_in, 100);
        wait_valid(cyc);
        check_eq("ab_rerun_idx", res_if.res_idx, 0);
        tick();
        check_eq("ab_rerun_done", done, 1);

        // reset mid-sequence
        do_start(2);
        tick(); tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_v_in", v_in, 0);
        check_eq("mrst_valid", res_if.res_valid, 0);
        tick();
        check_eq("mrst_done", done, 0);

        // full-scale jump restarts the stable run
        v_out = -18'sd131072;
        do_start(1);
        cyc = 0;
        while (!res_if.res_valid && cyc < 400) begin
            if (cyc == 7) v_out = 18'sd131071;
            tick();
            cyc++;
        end
        check_eq("ext_latency", cyc, 17);
        check_eq("ext_value", res_if.res_value, 131071);
        check_eq("ext_to", res_if.res_timeout, 0);
        tick();

        // settle and timeout on the same cycle: settle wins
        v_out    = 18'sd77;
        max_hold = 16'd13;
        do_start(1);
        wait_valid(cyc);
        check_eq("tie_latency", cyc, 13);
        check_eq("tie_to", res_if.res_timeout, 0);
        tick();

        // one cycle shorter: timeout only
        max_hold = 16'd12;
        do_start(1);
        wait_valid(cyc);
        check_eq("to12_latency", cyc, 12);
        check_eq("to12_flag", res_if.res_timeout, 1);
        tick();

        // max_hold below min_hold: always times out
        min_hold = 16'd10;
        max_hold = 16'd5;
        do_start(1);
        wait_valid(cyc);
        check_eq("short_latency", cyc, 5);
        check_eq("short_flag", res_if.res_timeout, 1);
        tick();
        check_eq("short_done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
